qk_inst_sequencer: RTL

On-chip controller that drives the `fullchip` Q·K datapath through its 17-bit `inst` bus. It performs the whole job the bench used to hand-sequence: stream Q and K vectors in from a host valid/ready port, write them to qmem/kmem, load K into the processor array, execute, drain ofifo into pmem, and read pmem back to the host. It sits between the host/SoC interface and `fullchip`. It drives `mem_in`/`inst` and samples `fullchip.out`.

---
 rtl/qk_inst_sequencer_pkg.sv | 53 +++++
 rtl/qk_inst_sequencer_if.sv | 12 +
 rtl/qk_inst_sequencer_pack.sv | 28 ++
 rtl/qk_inst_sequencer.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/qk_inst_sequencer_pkg.sv
// qk_seq_pkg: shared types and constants for the Q.K instruction sequencer.
// Holds the FSM state encoding, the control-bit bundle fed to the packer and
// the bit/field positions of the 17-bit fullchip inst word.
package qk_seq_pkg;

   typedef enum logic [3:0] {
      IDLE,
      QWR,
      KWR,
      KLOAD,
      GAP1,
      EXEC,
      GAP2,
      DRAIN,
      READ,
      DONE
   } state_t;

   // Control bits of one inst word, before address fields are packed in.
   typedef struct packed {
      logic ofifo_rd;
      logic execute;
      logic load;
      logic qmem_rd;
      logic qmem_wr;
      logic kmem_rd;
      logic kmem_wr;
      logic pmem_rd;
      logic pmem_wr;
   } ctl_t;

   localparam int INST_W        = 17;
   localparam int INST_OFIFO_RD = 16;
   localparam int INST_EXECUTE  = 7;
   localparam int INST_LOAD     = 6;
   localparam int INST_QMEM_RD  = 5;
   localparam int INST_QMEM_WR  = 4;
   localparam int INST_KMEM_RD  = 3;
   localparam int INST_KMEM_WR  = 2;
   localparam int INST_PMEM_RD  = 1;
   localparam int INST_PMEM_WR  = 0;

   localparam int QKADD_LSB   = 12;
   localparam int PADD_LSB    = 8;
   localparam int ADD_FIELD_W = 4;

   // Address counters are narrower than the inst fields and zero-extended.
   localparam int ADD_W = 3;

   // Phase counter width; covers beat counts, col+2 and gap.
   localparam int CNT_W = 8;

endpackage

// File: rtl/qk_inst_sequencer_if.sv
// Host streaming port of the sequencer: valid/ready beat handshake carrying
// one Q or K vector per beat.
interface qk_inst_sequencer_if #(
   parameter int DATA_W = 64
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;

   modport master (output in_valid, output in_data, input in_ready);
   modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/qk_inst_sequencer_pack.sv
// qk_inst_pack: combinational packer from control bits and 3-bit addresses
// to the 17-bit fullchip inst word.
module qk_inst_pack
   import qk_seq_pkg::*;
(
   input  ctl_t               ctl_i,
   input  logic [ADD_W-1:0]   qkadd_i,
   input  logic [ADD_W-1:0]   padd_i,
   output logic [INST_W-1:0]  inst_o
);

   // Place each control bit and zero-extended address into its field.
   always_comb begin
      inst_o                              = '0;
      inst_o[INST_OFIFO_RD]               = ctl_i.ofifo_rd;
      inst_o[INST_EXECUTE]                = ctl_i.execute;
      inst_o[INST_LOAD]                   = ctl_i.load;
      inst_o[INST_QMEM_RD]                = ctl_i.qmem_rd;
      inst_o[INST_QMEM_WR]                = ctl_i.qmem_wr;
      inst_o[INST_KMEM_RD]                = ctl_i.kmem_rd;
      inst_o[INST_KMEM_WR]                = ctl_i.kmem_wr;
      inst_o[INST_PMEM_RD]                = ctl_i.pmem_rd;
      inst_o[INST_PMEM_WR]                = ctl_i.pmem_wr;
      inst_o[QKADD_LSB +: ADD_FIELD_W]    = ADD_FIELD_W'(qkadd_i);
      inst_o[PADD_LSB  +: ADD_FIELD_W]    = ADD_FIELD_W'(padd_i);
   end

endmodule

// File: rtl/qk_inst_sequencer.sv
// qk_inst_sequencer: drives the fullchip Q.K datapath through its inst bus.
// Streams Q then K vectors from the host into qmem/kmem, loads K, executes,
// drains ofifo into pmem and (optionally) reads pmem back to the host.
// Optional feature macro: QK_SEQ_READBACK_EN enables the READ phase and the
// rd_valid/rd_data capture path; without it DRAIN goes straight to DONE.
module qk_inst_sequencer
   import qk_seq_pkg::*;
#(
   parameter int bw          = 8,
   parameter int pr          = 8,
   parameter int col         = 8,
   parameter int total_cycle = 8,
   parameter int bw_psum     = 2*bw+4,
   parameter int gap         = 10
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   qk_inst_sequencer_if.slave      host,
   output logic [pr*bw-1:0]        mem_in,
   output logic [INST_W-1:0]       inst,
   input  logic [bw_psum*col-1:0]  out,
   output logic                    rd_valid,
   output logic [bw_psum*col-1:0]  rd_data,
   output logic                    busy,
   output logic                    done
);

   state_t              state_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [INST_W-1:0]   inst_q;
   logic [pr*bw-1:0]    mem_in_q;
   logic                in_ready_q;
   logic                busy_q;
   logic                done_q;

   ctl_t                ctl_d;
   logic [ADD_W-1:0]    qkadd_d;
   logic [ADD_W-1:0]    padd_d;
   logic [INST_W-1:0]   inst_d;
   logic                accept;

   assign accept        = in_ready_q & host.in_valid;
   assign host.in_ready = in_ready_q;
   assign inst          = inst_q;
   assign mem_in        = mem_in_q;
   assign busy          = busy_q;
   assign done          = done_q;

   // Decode the inst word for the current state/count; registered next edge.
   always_comb begin
      ctl_d   = '0;
      qkadd_d = '0;
      padd_d  = '0;
      case (state_q)
         QWR: begin
            if (accept) begin
               ctl_d.qmem_wr = 1'b1;
               qkadd_d       = cnt_q[ADD_W-1:0];
            end
         end
         KWR: begin
            if (accept) begin
               ctl_d.kmem_wr = 1'b1;
               qkadd_d       = cnt_q[ADD_W-1:0];
            end
         end
         KLOAD: begin
            ctl_d.load = 1'b1;
            if (cnt_q != '0 && cnt_q <= CNT_W'(col)) begin
               ctl_d.kmem_rd = 1'b1;
               qkadd_d       = ADD_W'(cnt_q - CNT_W'(1));
            end
         end
         EXEC: begin
            ctl_d.execute = 1'b1;
            ctl_d.qmem_rd = 1'b1;
            qkadd_d       = cnt_q[ADD_W-1:0];
         end
         DRAIN: begin
            ctl_d.ofifo_rd = 1'b1;
            ctl_d.pmem_wr  = 1'b1;
            padd_d         = cnt_q[ADD_W-1:0];
         end
         READ: begin
            // Final count value is the tail cycle: inst stays 0.
            if (cnt_q < CNT_W'(total_cycle)) begin
               ctl_d.pmem_rd = 1'b1;
               padd_d        = cnt_q[ADD_W-1:0];
            end
         end
         default: ;
      endcase
   end

   qk_inst_pack u_pack (
      .ctl_i   (ctl_d),
      .qkadd_i (qkadd_d),
      .padd_i  (padd_d),
      .inst_o  (inst_d)
   );

   // Sequencer FSM with phase counter and registered outputs.
   // inst/mem_in lag the state by one cycle (word decoded in state S shows
   // up the following cycle); in_ready/busy are set on the transition edge
   // so they line up with the state itself.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         inst_q     <= '0;
         mem_in_q   <= '0;
         in_ready_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         inst_q <= inst_d;
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  state_q    <= QWR;
                  cnt_q      <= '0;
                  in_ready_q <= 1'b1;
                  busy_q     <= 1'b1;
               end
            end
            QWR: begin
               if (accept) begin
                  mem_in_q <= host.in_data;
                  if (cnt_q == CNT_W'(total_cycle - 1)) begin
                     state_q <= KWR;
                     cnt_q   <= '0;
                  end else begin
                     cnt_q <= cnt_q + CNT_W'(1);
                  end
               end
            end
            KWR: begin
               if (accept) begin
                  mem_in_q <= host.in_data;
                  if (cnt_q == CNT_W'(col - 1)) begin
                     state_q    <= KLOAD;
                     cnt_q      <= '0;
                     in_ready_q <= 1'b0;
                  end else begin
                     cnt_q <= cnt_q + CNT_W'(1);
                  end
               end
            end
            KLOAD: begin
               if (cnt_q == CNT_W'(col + 1)) begin
                  state_q <= GAP1;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            GAP1: begin
               if (cnt_q == CNT_W'(gap - 1)) begin
                  state_q <= EXEC;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            EXEC: begin
               if (cnt_q == CNT_W'(total_cycle - 1)) begin
                  state_q <= GAP2;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            GAP2: begin
               if (cnt_q == CNT_W'(gap - 1)) begin
                  state_q <= DRAIN;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            DRAIN: begin
               if (cnt_q == CNT_W'(total_cycle - 1)) begin
`ifdef QK_SEQ_READBACK_EN
                  state_q <= READ;
`else
                  state_q <= DONE;
`endif
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            READ: begin
               if (cnt_q == CNT_W'(total_cycle)) begin
                  state_q <= DONE;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            DONE: begin
               state_q <= IDLE;
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

`ifdef QK_SEQ_READBACK_EN
   logic                    rd_pend_q;
   logic                    rd_valid_q;
   logic [bw_psum*col-1:0]  rd_data_q;

   // pmem_rd on inst in cycle c -> out valid in c+1 -> word presented in c+2.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_pend_q  <= 1'b0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         rd_pend_q  <= inst_q[INST_PMEM_RD];
         rd_valid_q <= rd_pend_q;
         if (rd_pend_q) begin
            rd_data_q <= out;
         end
      end
   end

   assign rd_valid = rd_valid_q;
   assign rd_data  = rd_data_q;
`else
   logic unused_out;

   assign unused_out = ^out;
   assign rd_valid   = 1'b0;
   assign rd_data    = '0;
`endif

endmodule
